// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - state encoding, config codes and saturating add shared by the LIF soma array
package lif_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED   = 2'b00,
      ST_ACTIVE     = 2'b01,
      ST_REFRACTORY = 2'b11
   } lif_state_t;

   localparam logic [1:0] SEL_THRESHOLD  = 2'd0;
   localparam logic [1:0] SEL_REFR_TIME  = 2'd1;
   localparam logic [1:0] SEL_LEAK_SHIFT = 2'd2;
   localparam logic [1:0] SEL_CONTROL    = 2'd3;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_KILL_BIT   = 1;

   // Operands are sign-extended to SAT_W bits so the raw sum can never wrap
   localparam int SAT_W = 64;

   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input int unsigned             w
   );
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      s  = a + b;
      hi = $signed((64'd1 << (w - 1)) - 64'd1);
      lo = ~hi;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational per-visit update of one soma: leak, fire, refractory countdown
module lif_update
   import lif_pkg::*;
#(
   parameter int V_W = 16,
   parameter int R_W = 8
) (
   input  logic signed [V_W-1:0] i_v,
   input  logic signed [V_W-1:0] i_threshold,
   input  logic [3:0]            i_leak_shift,
   input  logic [R_W-1:0]        i_refr_time,
   input  logic [1:0]            i_state,
   input  logic [R_W-1:0]        i_refr_cnt,
   output logic signed [V_W-1:0] o_v,
   output logic [1:0]            o_state,
   output logic [R_W-1:0]        o_refr_cnt,
   output logic                  o_fire
);

   // A zero shift subtracts v from itself, i.e. a full leak
   logic signed [V_W-1:0] w_vl;
   assign w_vl = i_v - (i_v >>> i_leak_shift);

   always_comb begin
      o_v        = i_v;
      o_state    = i_state;
      o_refr_cnt = i_refr_cnt;
      o_fire     = 1'b0;
      case (i_state)
         ST_ACTIVE: begin
            if (w_vl >= i_threshold) begin
               o_v        = '0;
               o_state    = ST_REFRACTORY;
               o_refr_cnt = (i_refr_time == '0) ? R_W'(1) : i_refr_time;
               o_fire     = 1'b1;
            end else begin
               o_v = w_vl;
            end
         end
         ST_REFRACTORY: begin
            if (i_refr_cnt <= R_W'(1)) begin
               o_refr_cnt = '0;
               o_state    = ST_ACTIVE;
            end else begin
               o_refr_cnt = i_refr_cnt - R_W'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lif_soma_array.sv
// rtl/lif_soma_array.sv - time-multiplexed array of LIF somas; per-neuron register file,
// weight accumulation, one-neuron-per-clock sweep on tick and spike output register
module lif_soma_array
   import lif_pkg::*;
#(
   parameter int N_NEURON = 4,
   parameter int V_W      = 16,
   parameter int W_W      = 16,
   parameter int R_W      = 8,
   parameter int ID_W     = $clog2(N_NEURON)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [ID_W-1:0] cfg_id,
   input  logic [1:0]      cfg_sel,
   input  logic [V_W-1:0]  cfg_data,
   input  logic            syn_valid,
   output logic            syn_ready,
   input  logic [ID_W-1:0] syn_id,
   input  logic [W_W-1:0]  syn_weight,
   input  logic            tick,
   output logic            busy,
   output logic            spike_valid,
   output logic [ID_W-1:0] spike_id,
   output logic            overrun
);

   localparam logic signed [V_W-1:0] TH_RESET = {1'b0, {(V_W-1){1'b1}}};

   logic signed [V_W-1:0] r_v         [N_NEURON];
   logic signed [V_W-1:0] r_th        [N_NEURON];
   logic [R_W-1:0]        r_refr_time [N_NEURON];
   logic [3:0]            r_leak      [N_NEURON];
   logic [1:0]            r_state     [N_NEURON];
   logic [R_W-1:0]        r_cnt       [N_NEURON];

   logic            r_busy;
   logic [ID_W-1:0] r_idx;
   logic            r_spike_valid;
   logic [ID_W-1:0] r_spike_id;
   logic            r_overrun;

   logic signed [V_W-1:0] w_v_nxt;
   logic [1:0]            w_state_nxt;
   logic [R_W-1:0]        w_cnt_nxt;
   logic                  w_fire;
   logic                  w_cfg_kill;
   logic                  w_kill_visit;
   logic                  w_syn_fire;
   logic signed [V_W-1:0] w_acc;

   lif_update #(
      .V_W (V_W),
      .R_W (R_W)
   ) u_update (
      .i_v          (r_v[r_idx]),
      .i_threshold  (r_th[r_idx]),
      .i_leak_shift (r_leak[r_idx]),
      .i_refr_time  (r_refr_time[r_idx]),
      .i_state      (r_state[r_idx]),
      .i_refr_cnt   (r_cnt[r_idx]),
      .o_v          (w_v_nxt),
      .o_state      (w_state_nxt),
      .o_refr_cnt   (w_cnt_nxt),
      .o_fire       (w_fire)
   );

   assign w_cfg_kill   = cfg_data[CTRL_KILL_BIT] | ~cfg_data[CTRL_ENABLE_BIT];
   // A kill landing on the neuron being visited must also swallow its spike
   assign w_kill_visit = r_busy && cfg_we && (cfg_sel == SEL_CONTROL) && w_cfg_kill && (cfg_id == r_idx);
   assign w_syn_fire   = syn_valid && !r_busy;
   assign w_acc        = V_W'(sat_add(SAT_W'(r_v[syn_id]), SAT_W'($signed(syn_weight)), V_W));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_NEURON; i++) begin
            r_v[i]         <= '0;
            r_th[i]        <= TH_RESET;
            r_refr_time[i] <= '0;
            r_leak[i]      <= '0;
            r_state[i]     <= ST_DISABLED;
            r_cnt[i]       <= '0;
         end
         r_busy        <= 1'b0;
         r_idx         <= '0;
         r_spike_valid <= 1'b0;
         r_spike_id    <= '0;
         r_overrun     <= 1'b0;
      end else begin
         r_spike_valid <= 1'b0;
         if (tick) begin
            if (r_busy) begin
               r_overrun <= 1'b1;
            end else begin
               r_busy <= 1'b1;
               r_idx  <= '0;
            end
         end
         if (r_busy) begin
            r_v[r_idx]     <= w_v_nxt;
            r_state[r_idx] <= w_state_nxt;
            r_cnt[r_idx]   <= w_cnt_nxt;
            if (w_fire && !w_kill_visit) begin
               r_spike_valid <= 1'b1;
               r_spike_id    <= r_idx;
            end
            if (r_idx == ID_W'(N_NEURON - 1))
               r_busy <= 1'b0;
            else
               r_idx <= r_idx + ID_W'(1);
         end
         if (w_syn_fire && (r_state[syn_id] == ST_ACTIVE))
            r_v[syn_id] <= w_acc;
         // Config writes come last so they override a same-cycle visit result
         if (cfg_we) begin
            case (cfg_sel)
               SEL_THRESHOLD:  r_th[cfg_id]        <= $signed(cfg_data);
               SEL_REFR_TIME:  r_refr_time[cfg_id] <= cfg_data[R_W-1:0];
               SEL_LEAK_SHIFT: r_leak[cfg_id]      <= cfg_data[3:0];
               default: begin
                  if (w_cfg_kill) begin
                     r_state[cfg_id] <= ST_DISABLED;
                     r_v[cfg_id]     <= '0;
                     r_cnt[cfg_id]   <= '0;
                  end else if (r_state[cfg_id] == ST_DISABLED) begin
                     r_state[cfg_id] <= ST_ACTIVE;
                  end
               end
            endcase
         end
      end
   end

   assign syn_ready   = !r_busy;
   assign busy        = r_busy;
   assign spike_valid = r_spike_valid;
   assign spike_id    = r_spike_id;
   assign overrun     = r_overrun;

endmodule

// File: doc/lif_soma_array.md
Name: lif_soma_array

Overview:
Time-multiplexed array of N leaky integrate-and-fire somas, parametrised in neuron count and datapath widths. It is the successor to the single-neuron soma.
- Accumulates signed synaptic weights per neuron.
- Applies shift-based leak, threshold fire and refractory countdown once per global timestep tick, sweeping one neuron per clock.
- Sits between the synapse block (weights) and the spike router (spike events).
- Configured per neuron by the PN controller.

Parameters:
N_NEURON, 4, neurons in the array (power of 2, >=2)
V_W, 16, membrane potential / threshold width (signed)
W_W, 16, synaptic weight width (signed, W_W <= V_W)
R_W, 8, refractory counter width
ID_W, $clog2(N_NEURON), neuron index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_we  in  1  config write strobe
cfg_id  in  ID_W  target neuron
cfg_sel  in  2  field: 0 threshold, 1 refr_time, 2 leak_shift, 3 control
cfg_data  in  V_W  write data (control: bit0 enable, bit1 kill)
syn_valid  in  1  weight valid
syn_ready  out  1  weight accepted when valid&ready
syn_id  in  ID_W  destination neuron
syn_weight  in  W_W  signed weight
tick  in  1  timestep pulse
busy  out  1  sweep in progress
spike_valid  out  1  one-cycle spike pulse
spike_id  out  ID_W  firing neuron
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: v=0, threshold=max positive, refr_time=0, leak_shift=0, state DISABLED, refr_cnt=0. Outputs busy=0, spike_valid=0, spike_id=0, overrun=0; syn_ready=1.
- Per-neuron state machine, states DISABLED, ACTIVE, REFRACTORY:
  - DISABLED -> ACTIVE on control write with enable=1.
  - Any state -> DISABLED on control write with kill=1 or enable=0. This also clears v and refr_cnt.
  - ACTIVE -> REFRACTORY on fire.
  - REFRACTORY -> ACTIVE when refr_cnt expires.
- Config writes take effect the next cycle. Writes to threshold, refr_time and leak_shift are accepted in any state. leak_shift uses the low 4 bits.
- Accumulate:
  - syn_ready = !busy.
  - On a handshake to an ACTIVE neuron: v <= sat(v + sign_ext(weight)), saturating to the signed V_W range.
  - Handshakes to DISABLED or REFRACTORY neurons are accepted and dropped.
- Sweep:
  - tick while !busy at cycle t: busy=1 for cycles t+1..t+N_NEURON.
  - Neuron i is visited at cycle t+1+i.
  - tick while busy is ignored and sets overrun.
- Visit of an ACTIVE neuron:
  - vl = v - (v >>> leak_shift), arithmetic shift. leak_shift=0 gives vl=0 (full leak).
  - If vl >= threshold (signed compare): v <= 0, refr_cnt <= max(refr_time,1), state REFRACTORY, fire.
  - Otherwise v <= vl.
- Visit of a REFRACTORY neuron: refr_cnt decrements. On reaching 0, state becomes ACTIVE in the same visit, with no leak or fire that visit. Refractory therefore spans exactly max(refr_time,1) ticks.
- Visit of a DISABLED neuron: no action.
- Fire output: spike_valid=1 and spike_id=i at cycle t+2+i, one cycle wide. There is no backpressure.
- Simultaneous events:
  - A config write on the cycle its neuron is visited: the visit uses the old field values, and the write lands afterwards.
  - A kill on the visit cycle wins over the visit result, so no spike is emitted.
- Reset asserted mid-sweep aborts the sweep. All state returns to reset values and no partial spike is emitted.

Decomposition:
- Package lif_pkg holds:
  - state encoding (DISABLED=2'b00, ACTIVE=2'b01, REFRACTORY=2'b11)
  - cfg_sel codes
  - control bit positions
  - the saturating-add function
- One combinational sub-module, lif_update. It takes v, threshold, leak_shift, state and refr_cnt, and returns next v, state, refr_cnt and fire.
- lif_soma_array holds the register file, config/accumulate ports, sweep counter and spike output register.

Test Plan:
- Reset, enable n0 with th=100, leak_shift=15, weights 60 then 50, then tick -> spike_valid with spike_id=0 two cycles after tick; v0=0; n0 REFRACTORY.
- refr_time=3 after a fire; weights sent during the next 3 ticks are dropped -> n0 ACTIVE after the 3rd tick visit; a 120 weight then fires on the following tick.
- leak_shift=1, th=1000, v=512 -> v after successive ticks is 256, 128, 64; no spike.
- Weights +30000 twice, V_W=16 -> v saturates at 32767; negative sat at -32768 with two -30000 weights.
- tick again 2 cycles after tick, N_NEURON=4 -> overrun=1 (sticky); only one sweep (busy 4 cycles); syn_ready=0 while busy.
- Kill n2 on its visit cycle while it would fire -> no spike_valid, v2=0, n2 DISABLED; rst asserted mid-sweep -> busy=0 and no spikes.
